// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 responder bridging a 4-wire link onto a byte-wide
// register bus. Command byte = {R/W, addr[6:0]}, then data bytes with address
// auto-increment. All SPI pins are oversampled in clk; nothing runs on SCK.
// Optional feature macro: SPI_STATUS_EN (internal status register at STATUS_ADDR).
module spi_reg_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] STATUS_ADDR = 7'h7F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_csb,
    input  logic       spi_sck,
    input  logic       spi_sdi,
    output logic       spi_sdo,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    logic [SYNC_STAGES-1:0] csb_sync_q, sck_sync_q, sdi_sync_q, vld_sync_q;
    logic csb_prev_q, sck_prev_q, armed_q, armed_d;
    logic csb_s, sck_s, sdi_s;
    logic csb_fall, csb_rise, sck_rise, sck_fall;

    // Synchronize the SPI pins and keep one-cycle-old copies for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb_sync_q <= '1;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            vld_sync_q <= '0;
            csb_prev_q <= 1'b1;
            sck_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
            vld_sync_q <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
            csb_prev_q <= csb_s;
            sck_prev_q <= sck_s;
            armed_q    <= armed_d;
        end
    end

    assign csb_s = csb_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    // A CSB held low across reset must not start a transaction: only accept a
    // fall once CSB has been seen high through a freshly filled synchronizer.
    assign armed_d  = armed_q | (vld_sync_q[SYNC_STAGES-1] & csb_s);
    assign csb_fall = armed_q & csb_prev_q & ~csb_s;
    assign csb_rise = ~csb_prev_q & csb_s;
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d, re_q, re_d;
    logic       rd_q, rd_d;      // read issued (external or status)
    logic       pend_q, pend_d;  // read data is valid this cycle, load tx
    logic       inc_q, inc_d;    // post-write address increment
    logic [7:0] rx_byte;
    logic [6:0] rd_addr;
    logic       last_bit;
`ifdef SPI_STATUS_EN
    logic       st_rd_q, st_rd_d, st_pend_q, st_pend_d;
    logic [3:0] txn_cnt_q, txn_cnt_d;
    logic       abort_q, abort_d;
`else
    logic       unused_status;
    assign unused_status = ^STATUS_ADDR;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            rd_q      <= 1'b0;
            pend_q    <= 1'b0;
            inc_q     <= 1'b0;
`ifdef SPI_STATUS_EN
            st_rd_q   <= 1'b0;
            st_pend_q <= 1'b0;
            txn_cnt_q <= '0;
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            rd_q      <= rd_d;
            pend_q    <= pend_d;
            inc_q     <= inc_d;
`ifdef SPI_STATUS_EN
            st_rd_q   <= st_rd_d;
            st_pend_q <= st_pend_d;
            txn_cnt_q <= txn_cnt_d;
            abort_q   <= abort_d;
`endif
        end
    end

    // Next-state: byte framing, command decode, strobes and tx shifting.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        rd_d      = 1'b0;
        pend_d    = rd_q;
        inc_d     = 1'b0;
        rx_byte   = {rx_q, sdi_s};
        rd_addr   = addr_q + 7'd1;
        last_bit  = sck_rise && (bit_cnt_q == 3'd7);
`ifdef SPI_STATUS_EN
        st_rd_d   = 1'b0;
        st_pend_d = st_rd_q;
        txn_cnt_d = txn_cnt_q;
        abort_d   = abort_q;
`endif
        if (inc_q) addr_d = addr_q + 7'd1;

        // Read data arrives the cycle after the strobe; the status register
        // read also clears the sticky abort flag.
        if (pend_q) begin
`ifdef SPI_STATUS_EN
            if (st_pend_q) begin
                tx_d    = {txn_cnt_q, 3'b000, abort_q};
                abort_d = 1'b0;
            end else begin
                tx_d = reg_rdata;
            end
`else
            tx_d = reg_rdata;
`endif
        end

        case (state_q)
            IDLE: begin
                if (csb_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                    tx_d      = '0;
                end
            end
            default: begin
                if (sck_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                // No shift at bit_cnt 0 so a freshly loaded MSB survives the
                // first SCK fall of each byte.
                if (sck_fall && (bit_cnt_q != 3'd0)) tx_d = {tx_q[6:0], 1'b0};
                if (last_bit) begin
                    case (state_q)
                        CMD: begin
                            addr_d = rx_byte[6:0];
                            if (rx_byte[7]) begin
                                state_d = WDATA;
                            end else begin
                                state_d = RDATA;
                                rd_d    = 1'b1;
                                rd_addr = rx_byte[6:0];
                            end
                        end
                        WDATA: begin
                            inc_d   = 1'b1;
                            we_d    = 1'b1;
                            wdata_d = rx_byte;
`ifdef SPI_STATUS_EN
                            if (addr_q == STATUS_ADDR) begin
                                we_d    = 1'b0;
                                wdata_d = wdata_q;
                            end
`endif
                        end
                        RDATA: begin
                            addr_d = addr_q + 7'd1;
                            rd_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (csb_rise) begin
                    state_d = IDLE;
`ifdef SPI_STATUS_EN
                    if ((bit_cnt_q == 3'd0) || last_bit) txn_cnt_d = txn_cnt_q + 4'd1;
                    else abort_d = 1'b1;
`endif
                end
            end
        endcase

        if (rd_d) begin
            re_d = 1'b1;
`ifdef SPI_STATUS_EN
            if (rd_addr == STATUS_ADDR) begin
                re_d    = 1'b0;
                st_rd_d = 1'b1;
            end
`endif
        end
    end

    assign busy      = ~csb_s;
    assign spi_sdo   = busy & tx_q[7];
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed SPI transactions against a transaction-level model
// (expected strobe queue + shadow register memory), with a per-cycle compare process.
module tb_spi_reg_slave;
`ifdef SPI_STATUS_EN
    localparam bit STATUS_ON = 1'b1;
`else
    localparam bit STATUS_ON = 1'b0;
`endif

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
    } strobe_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_csb = 1'b1, spi_sck = 1'b0, spi_sdi = 1'b0;
    logic       spi_sdo, reg_we, reg_re, busy;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic       preload = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [7:0] regfile [128];   // core-side register file driven by DUT strobes
    logic [7:0] ref_mem [128];   // model's view of register contents
    logic [7:0] mosi [16];
    logic [7:0] miso [16];
    logic [7:0] exp_miso [16];
    int         n_rd;
    strobe_t    exp_q [$];
    logic [3:0] st_cnt = 4'd0;
    logic       st_abort = 1'b0;

    always #5 clk = ~clk;

    spi_reg_slave #(.SYNC_STAGES(2), .STATUS_ADDR(7'h7F)) dut (
        .clk(clk), .rst_n(rst_n), .spi_csb(spi_csb), .spi_sck(spi_sck),
        .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    function automatic logic [7:0] init_val(input int i);
        if (i == 16) return 8'hA1;
        if (i == 17) return 8'h5E;
        return 8'(i * 7 + 3);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Register file: preloaded, written by reg_we, read data valid the cycle after reg_re.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) regfile[i] <= init_val(i);
        end else if (reg_we) begin
            regfile[reg_addr] <= reg_wdata;
        end
        if (reg_re) reg_rdata <= regfile[reg_addr];
    end

    // Every strobe must match the next expected one; SDO must be 0 when not busy.
    always @(negedge clk) begin
        strobe_t e;
        if (reg_we || reg_re) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got we=%0b re=%0b addr=%h expected none",
                         reg_we, reg_re, reg_addr);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", {6'b0, reg_we, reg_re}, e.we ? 8'h02 : 8'h01);
                chk("strobe_addr", 8'(reg_addr), 8'(e.addr));
                if (e.we) chk("strobe_wdata", reg_wdata, e.data);
            end
        end
        if (!busy) chk("sdo_idle", 8'(spi_sdo), 8'h00);
    end

    // Transaction-level model: derive strobes and read-back bytes from the bits shifted.
    task automatic model_xfer(input int nbits);
        int         nb;
        logic [6:0] a;
        logic [7:0] cmd, v;
        nb   = nbits / 8;
        n_rd = 0;
        if (nb > 0) begin
            cmd = mosi[0];
            a   = cmd[6:0];
            if (cmd[7]) begin
                for (int k = 1; k < nb; k++) begin
                    if (!(STATUS_ON && a == 7'h7F)) begin
                        exp_q.push_back({1'b1, a, mosi[k]});
                        ref_mem[a] = mosi[k];
                    end
                    a = a + 7'd1;
                end
            end else begin
                for (int k = 0; k < nb; k++) begin
                    if (STATUS_ON && a == 7'h7F) begin
                        v        = {st_cnt, 3'b000, st_abort};
                        st_abort = 1'b0;
                    end else begin
                        v = ref_mem[a];
                        exp_q.push_back({1'b0, a, 8'h00});
                    end
                    exp_miso[k+1] = v;
                    a = a + 7'd1;
                end
                n_rd = nb - 1;
            end
        end
        if (nbits % 8 == 0) st_cnt = st_cnt + 4'd1;
        else st_abort = 1'b1;
    endtask

    task automatic csb_low();
        spi_csb = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic csb_high();
        repeat (6) @(negedge clk);
        spi_csb = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Mode 0: drive SDI while SCK low, sample SDO just before the rising edge.
    task automatic shift(input int first, input int last);
        for (int i = first; i < last; i++) begin
            spi_sdi = mosi[i/8][7 - i%8];
            repeat (6) @(negedge clk);
            miso[i/8][7 - i%8] = spi_sdo;
            spi_sck = 1'b1;
            repeat (6) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic run(input int nbits);
        model_xfer(nbits);
        csb_low();
        shift(0, nbits);
        csb_high();
        chk("strobes_left", 8'(exp_q.size()), 8'h00);
        for (int k = 1; k <= n_rd; k++) chk("miso_byte", miso[k], exp_miso[k]);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        repeat (3) @(negedge clk);
        preload = 1'b0;
        chk("rst_sdo", 8'(spi_sdo), 8'h00);
        chk("rst_addr", 8'(reg_addr), 8'h00);
        chk("rst_wdata", reg_wdata, 8'h00);
        chk("rst_we", 8'(reg_we), 8'h00);
        chk("rst_re", 8'(reg_re), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Burst write
        mosi[0] = 8'h85; mosi[1] = 8'h3C; mosi[2] = 8'hC3;
        run(24);
        chk("wr_0x05", regfile[5], 8'h3C);
        chk("wr_0x06", regfile[6], 8'hC3);
        chk("wr_final_addr", 8'(reg_addr), 8'h07);

        // Burst read
        mosi[0] = 8'h10; mosi[1] = 8'h00; mosi[2] = 8'h00;
        run(24);
        chk("rd_byte0", miso[1], 8'hA1);
        chk("rd_byte1", miso[2], 8'h5E);
        chk("rd_final_addr", 8'(reg_addr), 8'h12);

        // Address wrap
        mosi[0] = 8'hFF; mosi[1] = 8'h11; mosi[2] = 8'h22;
        run(24);
        chk("wrap_0x00", regfile[0], 8'h22);
`ifdef SPI_STATUS_EN
        chk("wrap_0x7f_dropped", regfile[127], init_val(127));
`else
        chk("wrap_0x7f", regfile[127], 8'h11);
`endif

        // Abort: partial data byte
        mosi[0] = 8'h82; mosi[1] = 8'hFF;
        run(13);
        chk("abort_busy", 8'(busy), 8'h00);
        chk("abort_sdo", 8'(spi_sdo), 8'h00);
        chk("abort_addr", 8'(reg_addr), 8'h02);
        mosi[0] = 8'h82; mosi[1] = 8'h99;
        run(16);
        chk("after_abort_wr", regfile[2], 8'h99);

        // Async reset in the middle of a read data byte
        mosi[0] = 8'h10; mosi[1] = 8'h00;
        exp_q.push_back({1'b0, 7'h10, 8'h00});
        csb_low();
        shift(0, 10);
        repeat (4) @(negedge clk);
        chk("pre_rst_sdo", 8'(spi_sdo), 8'h01);
        chk("pre_rst_addr", 8'(reg_addr), 8'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sdo", 8'(spi_sdo), 8'h00);
        chk("mid_rst_addr", 8'(reg_addr), 8'h00);
        chk("mid_rst_wdata", reg_wdata, 8'h00);
        chk("mid_rst_we", 8'(reg_we), 8'h00);
        chk("mid_rst_re", 8'(reg_re), 8'h00);
        chk("mid_rst_busy", 8'(busy), 8'h00);
        exp_q.delete();
        st_cnt = 4'd0;
        st_abort = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        // CSB still low: no fresh fall, so these bits must be ignored
        mosi[0] = 8'h85; mosi[1] = 8'h3C;
        shift(0, 16);
        csb_high();
        chk("no_fall_strobes", 8'(exp_q.size()), 8'h00);
        chk("no_fall_addr", 8'(reg_addr), 8'h00);
        mosi[0] = 8'h83; mosi[1] = 8'h5A;
        run(16);
        chk("post_rst_wr", regfile[3], 8'h5A);

`ifdef SPI_STATUS_EN
        // Status register: one abort, two writes, then two status reads
        rst_n = 1'b0;
        st_cnt = 4'd0;
        st_abort = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        mosi[0] = 8'h82; mosi[1] = 8'hFF;
        run(13);
        mosi[0] = 8'h83; mosi[1] = 8'h11;
        run(16);
        mosi[0] = 8'h84; mosi[1] = 8'h22;
        run(16);
        mosi[0] = 8'h7F; mosi[1] = 8'h00;
        run(16);
        chk("status_first", miso[1], 8'h21);
        run(16);
        chk("status_second", miso[1], 8'h30);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
SPI mode-0 responder that terminates the 4-wire link driven by the team's UART-to-SPI bridge and exposes a byte-wide register bus to the core. It decodes a command byte (R/W bit plus 7-bit address), then streams data bytes with address auto-increment. All SPI pins are oversampled in the `clk` domain; no logic runs on SCK.

Parameters:
SYNC_STAGES, 2, synchronizer depth on spi_csb/spi_sck/spi_sdi (legal 2..3)
STATUS_ADDR, 7'h7F, address claimed internally when SPI_STATUS_EN is defined

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
spi_csb  input  1  chip select, active low
spi_sck  input  1  SPI clock, CPOL=0
spi_sdi  input  1  MOSI
spi_sdo  output  1  MISO, always driven
reg_addr  output  7  register address
reg_wdata  output  8  write data
reg_we  output  1  one-cycle write strobe
reg_re  output  1  one-cycle read strobe
reg_rdata  input  8  read data, valid the cycle after reg_re
busy  output  1  synchronized CSB is low

Behaviour:
- Reset values: spi_sdo=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0; sync flops: csb=1, sck=0, sdi=0; state IDLE.
- Timing requirement on the SPI side: SCK high and low phases each >= 4 clk cycles; CSB setup/hold to first/last SCK edge >= 4 clk.
- Edge detection on synchronized signals; a "rise"/"fall" is a one-cycle pulse. Events below occur in the cycle after the pulse.
- bit_cnt (3 bit) counts SCK rises within a byte, MSB first; rx shift register captures synced sdi on rise.
- States: IDLE, CMD, WDATA, RDATA.
- IDLE -> CMD on CSB fall: bit_cnt=0, tx shift=0.
- CMD, 8th rise: cmd[7]=1 -> WDATA, reg_addr=cmd[6:0]. cmd[7]=0 -> RDATA, reg_addr=cmd[6:0], reg_re pulse.
- WDATA, each 8th rise: reg_wdata=byte, reg_we pulse 1 cycle; on the following cycle reg_addr increments.
- RDATA: cycle after reg_re, tx shift loads reg_rdata. After each later 8th rise: reg_addr increments, reg_re pulses, reload as above.
- SDO: spi_sdo = tx_shift[7] while busy, else 0. tx shift moves left on SCK fall only when bit_cnt != 0, so the freshly loaded MSB persists through the first fall of each byte. During CMD, SDO=0.
- Address wrap: 7'h7F increments to 7'h00.
- CSB rise at any point: return to IDLE next cycle. A partial byte is discarded with no reg_we/reg_re. spi_sdo goes to 0. reg_addr holds its value.
- CSB rise coincident with 8th rise: the byte completes (strobe issued), then IDLE.
- SCK edges while CSB high are ignored.
- Async reset mid-transaction: immediate reset values. The next transaction needs a fresh CSB fall.

Optional Feature:
Macro SPI_STATUS_EN.
- Defined: the internal status register answers reads at STATUS_ADDR instead of reg_rdata, and no reg_re is issued for it.
  - Status layout: bits[7:4] = count of completed transactions mod 16. bit0 = sticky abort flag, set when CSB rises with bit_cnt != 0 and cleared when status is read. Other bits 0.
  - Writes to STATUS_ADDR are dropped (no reg_we).
- Undefined: STATUS_ADDR behaves as an ordinary external address. Status logic is not present.

Test Plan:
- Write: CSB low, shift 8'h85, 8'h3C, 8'hC3, CSB high -> reg_we at addr 0x05 data 0x3C, then addr 0x06 data 0xC3. Exactly 2 strobes.
- Read: memory model 0x10=0xA1, 0x11=0x5E. Shift 8'h10 then 16 dummy bits -> SDO returns 0xA1 then 0x5E MSB-first. reg_re pulses at 0x10 and 0x11.
- Wrap: write burst with cmd 8'hFF and data 0x11, 0x22 -> writes to 0x7F then 0x00.
- Abort: cmd 8'h82, then 5 data bits, CSB high -> no reg_we, spi_sdo=0, busy=0. The next write to 0x02 succeeds.
- Reset: assert rst_n mid-read-byte -> all outputs at reset values in the same cycle. A following clean transaction works.
- SPI_STATUS_EN: after one abort and 2 completed transactions, read 0x7F -> 0x21. A second read returns 0x30 (abort flag cleared; the first read counts as a completed transaction).
